// File: rtl/cond_pkg.sv
// cond_pkg: shared types for the condition-flag unit.
//   br_type_t   : branch request kind (B, B.cond, CBZ, CBNZ)
//   cond_t      : LEGv8 condition codes EQ..NV
//   nzcv_t      : packed flag register {n, z, c, v}
//   out_state_t : state of the one-entry decision register
package cond_pkg;

   typedef enum logic [1:0] {
      BR_B    = 2'd0,
      BR_COND = 2'd1,
      BR_CBZ  = 2'd2,
      BR_CBNZ = 2'd3
   } br_type_t;

   typedef enum logic [3:0] {
      CC_EQ = 4'h0,
      CC_NE = 4'h1,
      CC_HS = 4'h2,
      CC_LO = 4'h3,
      CC_MI = 4'h4,
      CC_PL = 4'h5,
      CC_VS = 4'h6,
      CC_VC = 4'h7,
      CC_HI = 4'h8,
      CC_LS = 4'h9,
      CC_GE = 4'hA,
      CC_LT = 4'hB,
      CC_GT = 4'hC,
      CC_LE = 4'hD,
      CC_AL = 4'hE,
      CC_NV = 4'hF
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: bundle between the datapath/PC logic and cond_unit.
//   master : datapath side, drives ALU flags, set_flags, the branch request
//            (br_valid/br_type/br_cond) and res_ready; observes the rest.
//   slave  : cond_unit side, drives br_ready, res_valid, res_taken, flags,
//            br_count, taken_count.
// Parameter CNT_W must match the CNT_W of the attached cond_unit.
interface cond_unit_if #(
   parameter int CNT_W = 32
);
   import cond_pkg::*;

   logic             alu_negative;
   logic             alu_zero;
   logic             alu_overflow;
   logic             alu_carry_out;
   logic             set_flags;
   logic             br_valid;
   logic             br_ready;
   br_type_t         br_type;
   cond_t            br_cond;
   logic             res_valid;
   logic             res_ready;
   logic             res_taken;
   nzcv_t            flags;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output alu_negative, alu_zero, alu_overflow, alu_carry_out,
      output set_flags, br_valid, br_type, br_cond, res_ready,
      input  br_ready, res_valid, res_taken, flags, br_count, taken_count
   );

   modport slave (
      input  alu_negative, alu_zero, alu_overflow, alu_carry_out,
      input  set_flags, br_valid, br_type, br_cond, res_ready,
      output br_ready, res_valid, res_taken, flags, br_count, taken_count
   );

endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational LEGv8 condition evaluator. This is the single
// home of the B.cond condition table.
//   cond_i  : condition code
//   nzcv_i  : flags to evaluate against
//   taken_o : condition holds
module cond_eval
   import cond_pkg::*;
(
   input  cond_t cond_i,
   input  nzcv_t nzcv_i,
   output logic  taken_o
);

   logic ge;
   logic hi;
   logic gt;

   assign ge = (nzcv_i.n == nzcv_i.v);
   assign hi = nzcv_i.c & ~nzcv_i.z;
   assign gt = ~nzcv_i.z & ge;

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         CC_EQ:   taken_o =  nzcv_i.z;
         CC_NE:   taken_o = ~nzcv_i.z;
         CC_HS:   taken_o =  nzcv_i.c;
         CC_LO:   taken_o = ~nzcv_i.c;
         CC_MI:   taken_o =  nzcv_i.n;
         CC_PL:   taken_o = ~nzcv_i.n;
         CC_VS:   taken_o =  nzcv_i.v;
         CC_VC:   taken_o = ~nzcv_i.v;
         CC_HI:   taken_o =  hi;
         CC_LS:   taken_o = ~hi;
         CC_GE:   taken_o =  ge;
         CC_LT:   taken_o = ~ge;
         CC_GT:   taken_o =  gt;
         CC_LE:   taken_o = ~gt;
         // NV behaves as "always" in LEGv8, same as AL.
         CC_AL:   taken_o = 1'b1;
         CC_NV:   taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, branch-condition resolver and branch
// statistics for the CPU datapath.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : cond_unit_if.slave (ALU flags, set_flags, branch request
//           handshake, registered decision handshake, flags, counters)
// Build option: COND_UNIT_FWD_EN -- when defined, a B.cond accepted in the
// same cycle as set_flags evaluates on the incoming ALU flags; otherwise it
// evaluates on the register value from before the update.
//
// Output-register states:
//   state    | meaning
//   ST_EMPTY | no decision held, res_valid=0
//   ST_FULL  | decision held in taken_q, res_valid=1
module cond_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   cond_unit_if.slave  bus
);

   out_state_t       state_q, state_d;
   nzcv_t            flags_q, flags_d;
   logic             taken_q, taken_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

   nzcv_t            alu_nzcv;
   nzcv_t            eval_nzcv;
   logic             cond_taken;
   logic             dec_taken;
   logic             res_valid;
   logic             br_ready;
   logic             accept;
   logic             drain;

   assign alu_nzcv = '{n: bus.alu_negative, z: bus.alu_zero,
                       c: bus.alu_carry_out, v: bus.alu_overflow};

`ifdef COND_UNIT_FWD_EN
   assign eval_nzcv = bus.set_flags ? alu_nzcv : flags_q;
`else
   assign eval_nzcv = flags_q;
`endif

   cond_eval u_cond_eval (
      .cond_i  (bus.br_cond),
      .nzcv_i  (eval_nzcv),
      .taken_o (cond_taken)
   );

   // CBZ/CBNZ test the live ALU zero flag, not the registered Z.
   always_comb begin
      dec_taken = 1'b0;
      case (bus.br_type)
         BR_B:    dec_taken = 1'b1;
         BR_COND: dec_taken = cond_taken;
         BR_CBZ:  dec_taken = bus.alu_zero;
         BR_CBNZ: dec_taken = ~bus.alu_zero;
         default: dec_taken = 1'b0;
      endcase
   end

   assign accept = bus.br_valid & br_ready;
   assign drain  = res_valid & bus.res_ready;

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept)           state_d = ST_FULL;
         ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // FSM: outputs
   always_comb begin
      res_valid = (state_q == ST_FULL);
      br_ready  = ~res_valid | bus.res_ready;
   end

   // Datapath next-state: flag register, held decision, saturating counters.
   always_comb begin
      flags_d  = bus.set_flags ? alu_nzcv : flags_q;
      taken_d  = accept ? dec_taken : taken_q;
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      if (accept && !(&br_cnt_q)) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (accept && dec_taken && !(&tk_cnt_q)) begin
         tk_cnt_d = tk_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q  <= '0;
         taken_q  <= 1'b0;
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
      end else begin
         flags_q  <= flags_d;
         taken_q  <= taken_d;
         br_cnt_q <= br_cnt_d;
         tk_cnt_q <= tk_cnt_d;
      end
   end

   assign bus.br_ready    = br_ready;
   assign bus.res_valid   = res_valid;
   assign bus.res_taken   = taken_q;
   assign bus.flags       = flags_q;
   assign bus.br_count    = br_cnt_q;
   assign bus.taken_count = tk_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed scenarios plus randomized traffic for cond_unit,
// checked against a transaction-level reference model. A second instance
// with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_cond_unit;
   import cond_pkg::*;

   logic       clk;
   logic       reset;
   logic       br_valid, set_flags, res_ready;
   logic       an, az, ac, av;
   logic [1:0] br_type;
   logic [3:0] br_cond;

   int tests;
   int fails;

   // reference model state
   bit       m_valid;
   bit       m_taken;
   bit [3:0] m_flags;   // {N,Z,C,V}
   longint   m_br;
   longint   m_tk;
   bit       prev_stall;

   cond_unit_if #(.CNT_W(32)) bus ();
   cond_unit_if #(.CNT_W(2))  bs  ();

   assign bus.alu_negative  = an;
   assign bus.alu_zero      = az;
   assign bus.alu_carry_out = ac;
   assign bus.alu_overflow  = av;
   assign bus.set_flags     = set_flags;
   assign bus.br_valid      = br_valid;
   assign bus.br_type       = br_type_t'(br_type);
   assign bus.br_cond       = cond_t'(br_cond);
   assign bus.res_ready     = res_ready;

   assign bs.alu_negative   = an;
   assign bs.alu_zero       = az;
   assign bs.alu_carry_out  = ac;
   assign bs.alu_overflow   = av;
   assign bs.set_flags      = set_flags;
   assign bs.br_valid       = br_valid;
   assign bs.br_type        = br_type_t'(br_type);
   assign bs.br_cond        = cond_t'(br_cond);
   assign bs.res_ready      = res_ready;

   cond_unit #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   cond_unit #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(bs));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Condition codes come in pairs: even code tests a predicate, odd code
   // tests its negation; the last pair (AL/NV) is unconditional.
   function automatic bit ref_cond(int cc, bit [3:0] f);
      bit n, z, c, v, r;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc / 2)
         0: r = z;
         1: r = c;
         2: r = n;
         3: r = v;
         4: r = c && !z;
         5: r = (n == v);
         6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (cc < 14 && (cc % 2) == 1) r = !r;
      return r;
   endfunction

   function automatic longint sat3(longint x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic check_outputs();
      chk("res_valid",   bus.res_valid,   m_valid);
      chk("res_taken",   bus.res_taken,   m_taken);
      chk("flags",       bus.flags,       m_flags);
      chk("br_count",    bus.br_count,    m_br);
      chk("taken_count", bus.taken_count, m_tk);
      chk("br_count_s",    bs.br_count,    sat3(m_br));
      chk("taken_count_s", bs.taken_count, sat3(m_tk));
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic step();
      bit       acc, tk, fwd;
      bit [3:0] ef;
      #1;
      chk("br_ready",   bus.br_ready, !m_valid || res_ready);
      chk("br_ready_s", bs.br_ready,  !m_valid || res_ready);
      acc = br_valid && (!m_valid || res_ready);
`ifdef COND_UNIT_FWD_EN
      fwd = 1'b1;
`else
      fwd = 1'b0;
`endif
      ef = (fwd && set_flags) ? {an, az, ac, av} : m_flags;
      case (br_type)
         2'd0:    tk = 1'b1;
         2'd1:    tk = ref_cond(int'(br_cond), ef);
         2'd2:    tk = az;
         default: tk = !az;
      endcase
      @(posedge clk);
      if (set_flags) m_flags = {an, az, ac, av};
      if (acc) begin
         m_valid = 1'b1;
         m_taken = tk;
         m_br++;
         if (tk) m_tk++;
      end else if (res_ready) begin
         m_valid = 1'b0;
      end
      prev_stall = br_valid && !acc;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drv(input bit v, input int t, input int c, input bit sf,
                      input bit n, input bit z, input bit cy, input bit ov, input bit rr);
      br_valid = v; br_type = 2'(t); br_cond = 4'(c); set_flags = sf;
      an = n; az = z; ac = cy; av = ov; res_ready = rr;
      step();
   endtask

   task automatic model_reset();
      m_valid = 0; m_taken = 0; m_flags = 4'h0; m_br = 0; m_tk = 0; prev_stall = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_valid", bus.res_valid,   1'b0);
      chk("rst_flags", bus.flags,       4'h0);
      chk("rst_brcnt", bus.br_count,    64'd0);
      chk("rst_tkcnt", bus.taken_count, 64'd0);
      model_reset();
      br_valid = 0; set_flags = 0; res_ready = 1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", bus.br_ready, 1'b1);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      tests = 0; fails = 0;
      br_valid = 0; set_flags = 0; res_ready = 1;
      an = 0; az = 0; ac = 0; av = 0; br_type = 0; br_cond = 0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // SUBS 4-2: N0 Z0 C1 V0, then HI / LS
      drv(0, 0, 0, 1, 0, 0, 1, 0, 1);
      drv(1, 1, 8, 0, 0, 0, 0, 0, 1);
      chk("hi_taken", bus.res_taken, 1'b1);
      drv(1, 1, 9, 0, 0, 0, 0, 0, 1);
      chk("ls_taken", bus.res_taken, 1'b0);
      chk("ls_tkcnt", bus.taken_count, 64'd1);
      chk("ls_brcnt", bus.br_count, 64'd2);

      // ADDS 0x7FFF..F+1: N1 Z0 C0 V1, then GE / LT / VS
      drv(0, 0, 0, 1, 1, 0, 0, 1, 1);
      drv(1, 1, 10, 0, 0, 0, 0, 0, 1);
      chk("ge_taken", bus.res_taken, 1'b1);
      drv(1, 1, 11, 0, 0, 0, 0, 0, 1);
      chk("lt_taken", bus.res_taken, 1'b0);
      drv(1, 1, 6, 0, 0, 0, 0, 0, 1);
      chk("vs_taken", bus.res_taken, 1'b1);

      // CBZ / CBNZ / B
      drv(1, 2, 0, 0, 0, 1, 0, 0, 1);
      chk("cbz_taken", bus.res_taken, 1'b1);
      drv(1, 3, 0, 0, 0, 1, 0, 0, 1);
      chk("cbnz_taken", bus.res_taken, 1'b0);
      drv(1, 0, 0, 0, 1, 0, 1, 1, 1);
      chk("b_taken", bus.res_taken, 1'b1);
      chk("sat_brcnt", bs.br_count, 64'd3);
      chk("sat_tkcnt", bs.taken_count, 64'd3);

      // stall 3 cycles, then back-to-back
      for (int i = 0; i < 3; i++) begin
         drv(1, 3, 0, 0, 0, 0, 0, 0, 0);
         chk("stall_taken", bus.res_taken, 1'b1);
         chk("stall_brcnt", bus.br_count, 64'd8);
      end
      for (int i = 0; i < 3; i++) begin
         drv(1, 2, 0, 0, 0, i % 2, 0, 0, 1);
         chk("b2b_valid", bus.res_valid, 1'b1);
      end
      chk("b2b_brcnt", bus.br_count, 64'd11);

      // same-cycle set_flags + B.cond MI with prior NZCV=0000
      drv(0, 0, 0, 1, 0, 0, 0, 0, 1);
      drv(1, 1, 4, 1, 1, 0, 1, 0, 1);
`ifdef COND_UNIT_FWD_EN
      chk("fwd_mi", bus.res_taken, 1'b1);
`else
      chk("fwd_mi", bus.res_taken, 1'b0);
`endif

      // reset while FULL with res_ready low
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // randomized traffic; stalled requests are held stable
      for (int i = 0; i < 400; i++) begin
         if (!prev_stall) begin
            br_valid = ($urandom_range(0, 3) != 0);
            br_type  = 2'($urandom_range(0, 3));
            br_cond  = 4'($urandom_range(0, 15));
         end
         set_flags = ($urandom_range(0, 2) == 0);
         an = 1'($urandom); az = 1'($urandom); ac = 1'($urandom); av = 1'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
